// File: rtl/ring_shift_sequencer.sv
// Sequencer for a circular right-shift register: runs the clear/preset load sequence,
// issues shift ticks (free-running or single-step) and tracks a shadow copy, steps and laps.
module ring_shift_sequencer #(
    parameter int WIDTH     = 5,
    parameter int DIV_WIDTH = 8,
    parameter int LAP_WIDTH = 8,
    localparam int STEP_W   = $clog2(WIDTH)
) (
    input  logic                 clockpulse,
    input  logic                 clear,
    input  logic                 load,
    input  logic [WIDTH-1:0]     pattern,
    input  logic                 run,
    input  logic                 step,
    input  logic [DIV_WIDTH-1:0] divide,
    output logic                 reg_clear,
    output logic                 preset_enable,
    output logic [WIDTH-1:0]     preset,
    output logic                 shift_tick,
    output logic [WIDTH-1:0]     shadow_q,
    output logic [STEP_W-1:0]    step_count,
    output logic [LAP_WIDTH-1:0] lap_count,
    output logic                 lap_done,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        LOAD  = 3'd2,
        READY = 3'd3,
        RUN   = 3'd4
    } state_t;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     pattern_q;
    logic [DIV_WIDTH-1:0] presc;
    logic                 presc_hit;

    function automatic logic [WIDTH-1:0] rotate_right(input logic [WIDTH-1:0] v);
        return {v[0], v[WIDTH-1:1]};
    endfunction

    function automatic logic [STEP_W-1:0] step_inc(input logic [STEP_W-1:0] v);
        return (v == LAST_STEP) ? '0 : v + STEP_W'(1);
    endfunction

    always_ff @(posedge clockpulse) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign presc_hit = (presc == divide);

    always_comb begin
        state_next    = state;
        reg_clear     = 1'b0;
        preset_enable = 1'b0;
        preset        = '0;
        busy          = 1'b0;
        shift_tick    = 1'b0;
        case (state)
            IDLE: begin
                if (load) state_next = CLR;
            end
            CLR: begin
                reg_clear  = 1'b1;
                busy       = 1'b1;
                state_next = load ? CLR : LOAD;
            end
            LOAD: begin
                preset_enable = 1'b1;
                preset        = pattern_q;
                busy          = 1'b1;
                state_next    = load ? CLR : READY;
            end
            READY: begin
                if (load) begin
                    state_next = CLR;
                end else if (run) begin
                    state_next = RUN;
                end else begin
                    shift_tick = step;
                end
            end
            RUN: begin
                // Leaving RUN (stop or load) never produces a tick in the same cycle.
                if (load) begin
                    state_next = CLR;
                end else if (!run) begin
                    state_next = READY;
                end else begin
                    shift_tick = presc_hit;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign lap_done = shift_tick && (step_count == LAST_STEP);

    always_ff @(posedge clockpulse) begin
        if (clear) begin
            pattern_q  <= '0;
            presc      <= '0;
            shadow_q   <= '0;
            step_count <= '0;
            lap_count  <= '0;
        end else begin
            if (load) begin
                pattern_q <= pattern;
            end
            // A divide lowered below the running count lets the count wrap naturally.
            if (state == RUN && run && !load) begin
                presc <= presc_hit ? '0 : presc + DIV_WIDTH'(1);
            end else begin
                presc <= '0;
            end
            if (state == LOAD) begin
                shadow_q   <= pattern_q;
                step_count <= '0;
                lap_count  <= '0;
            end else if (shift_tick) begin
                shadow_q   <= rotate_right(shadow_q);
                step_count <= step_inc(step_count);
                if (step_count == LAST_STEP) begin
                    lap_count <= lap_count + LAP_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ring_shift_sequencer.sv
// Bench for ring_shift_sequencer: directed scenarios plus randomized traffic, every cycle
// compared against a model built on tick totals since the last load.
module tb_ring_shift_sequencer;

    localparam int W    = 5;
    localparam int LAPS = 256;

    localparam int M_OFF        = 0;
    localparam int M_CLEARING   = 1;
    localparam int M_PRESETTING = 2;
    localparam int M_STOPPED    = 3;
    localparam int M_RUNNING    = 4;

    logic         clk = 1'b0;
    logic         clear, load, run, step;
    logic [W-1:0] pattern;
    logic [7:0]   divide;
    logic         reg_clear, preset_enable, shift_tick, lap_done, busy;
    logic [W-1:0] preset, shadow_q;
    logic [2:0]   step_count;
    logic [7:0]   lap_count;

    int n_vec = 0;
    int n_bad = 0;

    int           m_mode;
    logic [W-1:0] m_latched;
    logic [W-1:0] m_pat;
    int           m_ticks;
    int           m_presc;

    ring_shift_sequencer dut (
        .clockpulse   (clk),
        .clear        (clear),
        .load         (load),
        .pattern      (pattern),
        .run          (run),
        .step         (step),
        .divide       (divide),
        .reg_clear    (reg_clear),
        .preset_enable(preset_enable),
        .preset       (preset),
        .shift_tick   (shift_tick),
        .shadow_q     (shadow_q),
        .step_count   (step_count),
        .lap_count    (lap_count),
        .lap_done     (lap_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int k);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < k; i++) r = {r[0], r[W-1:1]};
        return r;
    endfunction

    task automatic model_reset();
        m_mode    = M_OFF;
        m_latched = '0;
        m_pat     = '0;
        m_ticks   = 0;
        m_presc   = 0;
    endtask

    // One clock cycle: drive at negedge, compare just after, then advance the model past the posedge.
    task automatic drive_cycle(input logic c, input logic l, input logic [W-1:0] p,
                               input logic r, input logic s, input logic [7:0] d);
        logic e_tick;
        @(negedge clk);
        clear = c; load = l; pattern = p; run = r; step = s; divide = d;
        #1;
        e_tick = 1'b0;
        if (!l) begin
            if (m_mode == M_STOPPED) e_tick = s && !r;
            else if (m_mode == M_RUNNING) e_tick = r && (m_presc == int'(d));
        end
        check_val("reg_clear", {31'd0, reg_clear}, {31'd0, m_mode == M_CLEARING});
        check_val("preset_enable", {31'd0, preset_enable}, {31'd0, m_mode == M_PRESETTING});
        check_val("preset", 32'(preset), (m_mode == M_PRESETTING) ? 32'(m_latched) : 32'd0);
        check_val("busy", {31'd0, busy},
                  {31'd0, (m_mode == M_CLEARING) || (m_mode == M_PRESETTING)});
        check_val("shift_tick", {31'd0, shift_tick}, {31'd0, e_tick});
        check_val("lap_done", {31'd0, lap_done}, {31'd0, e_tick && (m_ticks % W == W - 1)});
        check_val("shadow_q", 32'(shadow_q), 32'(rotr(m_pat, m_ticks % W)));
        check_val("step_count", 32'(step_count), 32'(m_ticks % W));
        check_val("lap_count", 32'(lap_count), 32'((m_ticks / W) % LAPS));
        if (c) begin
            model_reset();
        end else begin
            if (m_mode == M_PRESETTING) begin
                m_pat   = m_latched;
                m_ticks = 0;
            end else if (e_tick) begin
                m_ticks = (m_ticks + 1) % (W * LAPS);
            end
            if (l) m_latched = p;
            if (m_mode == M_RUNNING && r && !l)
                m_presc = (m_presc == int'(d)) ? 0 : (m_presc + 1) % 256;
            else
                m_presc = 0;
            if (l) m_mode = M_CLEARING;
            else case (m_mode)
                M_CLEARING:   m_mode = M_PRESETTING;
                M_PRESETTING: m_mode = M_STOPPED;
                M_STOPPED:    m_mode = r ? M_RUNNING : M_STOPPED;
                M_RUNNING:    m_mode = r ? M_RUNNING : M_STOPPED;
                default:      m_mode = M_OFF;
            endcase
        end
    endtask

    task automatic load_seq(input logic [W-1:0] p);
        drive_cycle(0, 1, p, 0, 0, 8'd0);
        drive_cycle(0, 0, '0, 0, 0, 8'd0);
        drive_cycle(0, 0, '0, 0, 0, 8'd0);
    endtask

    initial begin
        int n;
        logic r_lvl;
        logic [7:0] d_lvl;
        clear = 1'b1; load = 1'b0; pattern = '0; run = 1'b0; step = 1'b0; divide = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // Load 10000: CLR, LOAD, READY timing
        drive_cycle(0, 0, '0, 0, 1, 8'd0);
        check_val("t1_idle_tick", {31'd0, shift_tick}, 32'd0);
        drive_cycle(0, 1, 5'b10000, 0, 0, 8'd0);
        drive_cycle(0, 0, '0, 0, 0, 8'd0);
        check_val("t1_reg_clear", {31'd0, reg_clear}, 32'd1);
        drive_cycle(0, 0, '0, 0, 0, 8'd0);
        check_val("t1_preset_en", {31'd0, preset_enable}, 32'd1);
        check_val("t1_preset", 32'(preset), 32'h10);
        drive_cycle(0, 0, '0, 0, 0, 8'd0);
        check_val("t1_shadow", 32'(shadow_q), 32'h10);

        // Five single steps make one lap
        n = 0;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 0, '0, 0, 1, 8'd0);
            if (lap_done) n++;
            drive_cycle(0, 0, '0, 0, 0, 8'd0);
        end
        check_val("t2_lap_pulses", 32'(n), 32'd1);
        check_val("t2_lap_count", 32'(lap_count), 32'd1);
        check_val("t2_step_count", 32'(step_count), 32'd0);
        check_val("t2_shadow", 32'(shadow_q), 32'h10);

        // Free run, divide=3
        load_seq(5'b10000);
        n = 0;
        drive_cycle(0, 0, '0, 1, 0, 8'd3);
        for (int i = 0; i < 20; i++) begin
            drive_cycle(0, 0, '0, 1, 1, 8'd3);
            if (shift_tick) n++;
        end
        check_val("t3_ticks", 32'(n), 32'd5);
        drive_cycle(0, 0, '0, 1, 0, 8'd3);
        check_val("t3_lap_count", 32'(lap_count), 32'd1);
        check_val("t3_shadow", 32'(shadow_q), 32'h10);

        // Load aborts a run
        drive_cycle(0, 0, '0, 1, 0, 8'd0);
        drive_cycle(0, 1, 5'b10100, 1, 0, 8'd0);
        check_val("t4_abort_tick", {31'd0, shift_tick}, 32'd0);
        drive_cycle(0, 0, '0, 0, 0, 8'd0);
        drive_cycle(0, 0, '0, 0, 0, 8'd0);
        drive_cycle(0, 0, '0, 0, 0, 8'd0);
        check_val("t4_shadow", 32'(shadow_q), 32'h14);
        check_val("t4_steps", 32'(step_count), 32'd0);
        check_val("t4_laps", 32'(lap_count), 32'd0);

        // Clear during LOAD
        drive_cycle(0, 1, 5'b01011, 0, 0, 8'd0);
        drive_cycle(0, 0, '0, 0, 0, 8'd0);
        drive_cycle(1, 0, '0, 0, 0, 8'd0);
        drive_cycle(0, 0, '0, 0, 1, 8'd0);
        check_val("t5_tick", {31'd0, shift_tick}, 32'd0);
        check_val("t5_busy", {31'd0, busy}, 32'd0);
        check_val("t5_shadow", 32'(shadow_q), 32'd0);
        check_val("t5_pe", {31'd0, preset_enable}, 32'd0);

        // 256 laps at divide=0
        load_seq(5'b10000);
        n = 0;
        drive_cycle(0, 0, '0, 1, 0, 8'd0);
        for (int i = 0; i < W * LAPS; i++) begin
            drive_cycle(0, 0, '0, 1, 0, 8'd0);
            if (lap_done) n++;
        end
        check_val("t6_lap_pulses", 32'(n), 32'd256);
        drive_cycle(0, 0, '0, 0, 0, 8'd0);
        check_val("t6_lap_wrap", 32'(lap_count), 32'd0);

        // Randomized traffic
        r_lvl = 1'b0;
        d_lvl = 8'd2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) r_lvl = ~r_lvl;
            if ($urandom_range(0, 19) == 0)
                d_lvl = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
            drive_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 32) == 0,
                        W'($urandom), r_lvl, $urandom_range(0, 2) == 0, d_lvl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
